// File: rtl/counter_nx.sv
// counter_nx: CH-channel, W-bit timer/counter with a shared 15-bit prescaler,
// one-shot / auto-reload / PWM / free-run modes and sticky interrupt flags.
// W must be at least max(7, CH) so the control word and irq-clear mask fit in wdata_i.
module counter_nx #(
  parameter  int unsigned CH  = 4,
  parameter  int unsigned W   = 32,
  localparam int unsigned CHW = $clog2(CH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           we_i,
  input  logic [1:0]     wsel_i,
  input  logic [CHW-1:0] ch_i,
  input  logic [W-1:0]   wdata_i,
  input  logic [CHW-1:0] rd_ch_i,
  output logic [W-1:0]   rd_data_o,
  output logic [CH-1:0]  cnt_out_o,
  output logic [CH-1:0]  irq_o,
  output logic           irq_any_o
);

  localparam int unsigned PSW = 15;
  localparam logic [PSW-1:0] PS_ONES = '1;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_FREE    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    WSEL_RELOAD = 2'd0,
    WSEL_CMP    = 2'd1,
    WSEL_CTRL   = 2'd2,
    WSEL_CLR    = 2'd3
  } wsel_e;

  typedef struct packed {
    logic [3:0] ps;
    mode_e      mode;
    logic       en;
  } ctrl_t;

  logic [PSW-1:0]         pre_q, pre_d;
  logic [CH-1:0][W-1:0]   cnt_q, cnt_d;
  logic [CH-1:0][W-1:0]   reload_q, reload_d;
  logic [CH-1:0][W-1:0]   cmp_q, cmp_d;
  ctrl_t [CH-1:0]         ctrl_q, ctrl_d;
  logic [CH-1:0]          out_q, out_d;
  logic [CH-1:0]          irq_q, irq_d;

  wsel_e                  wsel_c;
  logic [CH-1:0][PSW-1:0] mask_c;
  logic [CH-1:0]          tick_c;
  logic [CH-1:0]          wr_hit_c;
  logic [W-1:0]           nxt_c;

  assign wsel_c = wsel_e'(wsel_i);

  // Tick when the low ps prescaler bits are all ones; ps=0 gives an empty mask, so every cycle.
  always_comb begin
    mask_c   = '0;
    tick_c   = '0;
    wr_hit_c = '0;
    for (int i = 0; i < CH; i++) begin
      mask_c[i]   = ~(PS_ONES << ctrl_q[i].ps);
      tick_c[i]   = (pre_q & mask_c[i]) == mask_c[i];
      wr_hit_c[i] = we_i && (wsel_c != WSEL_CLR) && (ch_i == CHW'(i));
    end
  end

  always_comb begin
    pre_d    = pre_q + PSW'(1);
    cnt_d    = cnt_q;
    reload_d = reload_q;
    cmp_d    = cmp_q;
    ctrl_d   = ctrl_q;
    out_d    = out_q;
    irq_d    = irq_q;
    nxt_c    = '0;

    // Clear first so a same-cycle terminal event below re-sets the flag.
    if (we_i && (wsel_c == WSEL_CLR)) begin
      irq_d = irq_q & ~wdata_i[CH-1:0];
    end

    for (int i = 0; i < CH; i++) begin
      nxt_c = (cnt_q[i] == '0) ? reload_q[i] : cnt_q[i] - W'(1);
      if (wr_hit_c[i]) begin
        case (wsel_c)
          WSEL_RELOAD: begin
            reload_d[i] = wdata_i;
            if (!ctrl_q[i].en) begin
              cnt_d[i] = wdata_i;
            end
          end
          WSEL_CMP: cmp_d[i] = wdata_i;
          default: begin
            ctrl_d[i] = ctrl_t'(wdata_i[6:0]);
            cnt_d[i]  = (mode_e'(wdata_i[2:1]) == MODE_FREE) ? '0 : reload_q[i];
            out_d[i]  = 1'b0;
          end
        endcase
      end else if (ctrl_q[i].en && tick_c[i]) begin
        case (ctrl_q[i].mode)
          MODE_ONESHOT: begin
            if (cnt_q[i] == '0) begin
              out_d[i]     = 1'b1;
              irq_d[i]     = 1'b1;
              ctrl_d[i].en = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] - W'(1);
            end
          end
          MODE_RELOAD: begin
            cnt_d[i] = nxt_c;
            if (cnt_q[i] == '0) begin
              out_d[i] = ~out_q[i];
              irq_d[i] = 1'b1;
            end
          end
          MODE_PWM: begin
            cnt_d[i] = nxt_c;
            out_d[i] = nxt_c < cmp_q[i];
            if (cnt_q[i] == '0) begin
              irq_d[i] = 1'b1;
            end
          end
          default: begin
            cnt_d[i] = cnt_q[i] + W'(1);
            out_d[i] = cnt_d[i][W-1];
            if (&cnt_q[i]) begin
              irq_d[i] = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      reload_q <= '0;
      cmp_q    <= '0;
      ctrl_q   <= '0;
      out_q    <= '0;
      irq_q    <= '0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      cmp_q    <= cmp_d;
      ctrl_q   <= ctrl_d;
      out_q    <= out_d;
      irq_q    <= irq_d;
    end
  end

  assign rd_data_o = cnt_q[rd_ch_i];
  assign cnt_out_o = out_q;
  assign irq_o     = irq_q;
  assign irq_any_o = |irq_q;

endmodule

// File: tb/tb_counter_nx.sv
// Self-checking bench for counter_nx: directed vector table, hand-written corner
// sequences and randomized traffic checked against an arithmetic reference model.
module tb_counter_nx;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         we = 1'b0;
  logic [1:0]   wsel = 2'd0;
  logic [1:0]   ch = 2'd0;
  logic [W-1:0] wdata = '0;
  logic [1:0]   rd_ch = 2'd0;
  logic [W-1:0] rd_data;
  logic [CH-1:0] cnt_out;
  logic [CH-1:0] irq;
  logic          irq_any;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter_nx #(.CH(CH), .W(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (we),
    .wsel_i    (wsel),
    .ch_i      (ch),
    .wdata_i   (wdata),
    .rd_ch_i   (rd_ch),
    .rd_data_o (rd_data),
    .cnt_out_o (cnt_out),
    .irq_o     (irq),
    .irq_any_o (irq_any)
  );

  // Reference model: plain integer state per channel, prescaler as a cycle counter.
  int m_cnt [CH];
  int m_rel [CH];
  int m_cmp [CH];
  int m_mode[CH];
  int m_ps  [CH];
  bit m_en  [CH];
  bit m_out [CH];
  bit m_irq [CH];
  int m_pre;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_cmp[i] = 0; m_mode[i] = 0; m_ps[i] = 0;
      m_en[i] = 0; m_out[i] = 0; m_irq[i] = 0;
    end
    m_pre = 0;
  endtask

  task automatic model_step(input bit w, input int s, input int c, input int d);
    int period;
    bit tk;
    if (w && s == 3) begin
      for (int i = 0; i < CH; i++) if (((d >> i) & 1) == 1) m_irq[i] = 0;
    end
    for (int i = 0; i < CH; i++) begin
      period = 1 << m_ps[i];
      tk = (m_pre % period) == period - 1;
      if (w && s != 3 && c == i) begin
        if (s == 0) begin
          m_rel[i] = d;
          if (!m_en[i]) m_cnt[i] = d;
        end else if (s == 1) begin
          m_cmp[i] = d;
        end else begin
          m_en[i]   = (d & 1) == 1;
          m_mode[i] = (d >> 1) & 3;
          m_ps[i]   = (d >> 3) & 15;
          m_cnt[i]  = (m_mode[i] == 3) ? 0 : m_rel[i];
          m_out[i]  = 0;
        end
      end else if (m_en[i] && tk) begin
        case (m_mode[i])
          0: if (m_cnt[i] == 0) begin m_out[i] = 1; m_irq[i] = 1; m_en[i] = 0; end
             else m_cnt[i] = m_cnt[i] - 1;
          1: if (m_cnt[i] == 0) begin m_cnt[i] = m_rel[i]; m_out[i] = !m_out[i]; m_irq[i] = 1; end
             else m_cnt[i] = m_cnt[i] - 1;
          2: begin
               if (m_cnt[i] == 0) begin m_cnt[i] = m_rel[i]; m_irq[i] = 1; end
               else m_cnt[i] = m_cnt[i] - 1;
               m_out[i] = m_cnt[i] < m_cmp[i];
             end
          default: begin
               if (m_cnt[i] == MOD - 1) m_irq[i] = 1;
               m_cnt[i] = (m_cnt[i] + 1) % MOD;
               m_out[i] = m_cnt[i] >= MOD / 2;
             end
        endcase
      end
    end
    m_pre = (m_pre + 1) % 32768;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Drive one cycle's inputs, advance the model, and return #1 after the edge.
  task automatic cyc(input bit w, input int s, input int c, input int d);
    we = w; wsel = 2'(s); ch = 2'(c); wdata = W'(d);
    model_step(w, s, c, d);
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic do_reset(input bit w, input int s, input int c, input int d);
    rst = 1'b1; we = w; wsel = 2'(s); ch = 2'(c); wdata = W'(d);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int eo, ei;
    eo = 0; ei = 0;
    for (int i = 0; i < CH; i++) begin
      rd_ch = 2'(i); #1;
      chk({tag, "_rd"}, 32'(rd_data), m_cnt[i]);
      eo |= int'(m_out[i]) << i;
      ei |= int'(m_irq[i]) << i;
    end
    chk({tag, "_out"}, 32'(cnt_out), eo);
    chk({tag, "_irq"}, 32'(irq), ei);
    chk({tag, "_irq_any"}, 32'(irq_any), (ei != 0) ? 1 : 0);
  endtask

  typedef struct {
    bit w; int s; int c; int d; int rc; int e_rd; int e_out; int e_irq;
  } vec_t;

  vec_t tbl[19];
  int pwm_rd [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
  int pwm_out[8] = '{0, 1, 1, 0, 0, 1, 1, 0};

  initial begin
    // one-shot on ch0, then auto-reload on ch1 with irq-clear collisions
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 3, 0, 3, 0, 0};
    tbl[2]  = '{1, 2, 0, 1, 0, 3, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 2, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 1};
    tbl[8]  = '{1, 0, 1, 1, 1, 1, 1, 1};
    tbl[9]  = '{1, 2, 1, 3, 1, 1, 1, 1};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 1, 1};
    tbl[11] = '{0, 0, 0, 0, 1, 1, 3, 3};
    tbl[12] = '{0, 0, 0, 0, 1, 0, 3, 3};
    tbl[13] = '{0, 0, 0, 0, 1, 1, 1, 3};
    tbl[14] = '{1, 3, 0, 2, 1, 0, 1, 1};
    tbl[15] = '{0, 0, 0, 0, 1, 1, 3, 3};
    tbl[16] = '{0, 0, 0, 0, 1, 0, 3, 3};
    tbl[17] = '{1, 3, 0, 2, 1, 1, 1, 3};
    tbl[18] = '{1, 3, 0, 3, 1, 0, 1, 0};

    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 19; k++) begin
      cyc(tbl[k].w, tbl[k].s, tbl[k].c, tbl[k].d);
      rd_ch = 2'(tbl[k].rc); #1;
      chk($sformatf("vec%0d_rd", k), 32'(rd_data), tbl[k].e_rd);
      chk($sformatf("vec%0d_out", k), 32'(cnt_out), tbl[k].e_out);
      chk($sformatf("vec%0d_irq", k), 32'(irq), tbl[k].e_irq);
      chk($sformatf("vec%0d_irq_any", k), 32'(irq_any), (tbl[k].e_irq != 0) ? 1 : 0);
    end

    // PWM on ch2: reload 3, compare 2
    cyc(1, 0, 2, 3);
    cyc(1, 1, 2, 2);
    cyc(1, 2, 2, 5);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0);
      rd_ch = 2'd2; #1;
      chk($sformatf("pwm%0d_rd", k), 32'(rd_data), pwm_rd[k]);
      chk($sformatf("pwm%0d_out", k), 32'(cnt_out[2]), pwm_out[k]);
      chk($sformatf("pwm%0d_irq", k), 32'(irq[2]), (k >= 3) ? 1 : 0);
    end

    // free-run ch3 with ps=2: exactly 4 increments in 16 cycles
    cyc(1, 2, 3, 8'h17);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 0, 0);
      rd_ch = 2'd3; #1;
      chk("ps2_step", 32'(rd_data), m_cnt[3]);
    end
    chk("ps2_total", 32'(rd_data), 4);

    // free-run ch3 with ps=0 through the 2^W-1 -> 0 wrap
    cyc(1, 2, 3, 8'h07);
    for (int k = 1; k <= MOD; k++) begin
      cyc(0, 0, 0, 0);
      rd_ch = 2'd3; #1;
      if (k == MOD / 2 - 1 || k == MOD / 2 || k == MOD - 1 || k == MOD) begin
        chk($sformatf("wrap%0d_rd", k), 32'(rd_data), k % MOD);
        chk($sformatf("wrap%0d_out", k), 32'(cnt_out[3]), ((k % MOD) >= MOD / 2) ? 1 : 0);
        chk($sformatf("wrap%0d_irq", k), 32'(irq[3]), (k == MOD) ? 1 : 0);
      end
    end

    // reload write to disabled ch0 loads count directly; compare write drops ch1 tick
    cyc(1, 0, 0, 8'h5A);
    rd_ch = 2'd0; #1;
    chk("reload_disabled", 32'(rd_data), 8'h5A);
    cyc(1, 1, 1, 8'h01);
    check_all("wr_drop");

    // reset mid-count with a pending write
    cyc(1, 0, 0, 100);
    cyc(1, 2, 0, 1);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    rd_ch = 2'd0; #1;
    chk("pre_rst_cnt", 32'(rd_data), 97);
    chk("pre_rst_irq1", 32'(irq[1]), 1);
    do_reset(1, 0, 0, 55);
    for (int i = 0; i < CH; i++) begin
      rd_ch = 2'(i); #1;
      chk($sformatf("rst_rd%0d", i), 32'(rd_data), 0);
    end
    chk("rst_out", 32'(cnt_out), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_irq_any", 32'(irq_any), 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0);
    rd_ch = 2'd0; #1;
    chk("rst_stays_disabled", 32'(rd_data), 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int s, d, ps;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1, 0, 0, int'($urandom_range(0, 255)));
      end else if ($urandom_range(0, 2) == 0) begin
        s = int'($urandom_range(0, 3));
        if (s == 2) begin
          ps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
          d = (($urandom_range(0, 3) != 0) ? 1 : 0) | (int'($urandom_range(0, 3)) << 1) | (ps << 3);
        end else if (s == 3) begin
          d = int'($urandom_range(0, 15));
        end else begin
          d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
        end
        cyc(1, s, int'($urandom_range(0, CH - 1)), d);
      end else begin
        cyc(0, 0, 0, 0);
      end
      check_all("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
